// File: rtl/pwm_fade_ctrl.sv
// Ramps a pwm duty value toward a commanded target, one step per (hold+1) period boundaries.
// Outputs registered; cmd_ready low while ramping, abort returns it high on the next edge.
module pwm_fade_ctrl #(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [WIDTH-1:0]  duty,
  output logic              pwm_enable,
  output logic              frame_sync,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0]  ONE_W   = 1;
  localparam logic [HOLD_W-1:0] ONE_H   = 1;
  localparam logic [WIDTH-1:0]  LAST_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state;
  logic [WIDTH-1:0]  period_cnt;
  logic [WIDTH-1:0]  tgt;
  logic [WIDTH-1:0]  step;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_cnt;

  logic              going_up;
  logic [WIDTH:0]    diff;
  logic              last_step;
  logic [WIDTH-1:0]  next_duty;

  // next_duty is only used when diff > step, so it can never wrap or overshoot
  always_comb begin
    going_up  = (tgt >= duty);
    diff      = going_up ? ({1'b0, tgt} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, tgt});
    last_step = (diff <= {1'b0, step});
    next_duty = going_up ? (duty + step) : (duty - step);
  end

  // frame_sync is registered, so it is raised on the edge that makes the counter all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      frame_sync <= 1'b0;
    end else begin
      period_cnt <= period_cnt + ONE_W;
      frame_sync <= (period_cnt == LAST_M1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      duty       <= '0;
      pwm_enable <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      tgt        <= '0;
      step       <= '0;
      hold       <= '0;
      hold_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tgt      <= cmd_target;
            step     <= (cmd_step == '0) ? ONE_W : cmd_step;
            hold     <= cmd_hold;
            hold_cnt <= '0;
            if (!(cmd_target == '0 && duty == '0))
              pwm_enable <= 1'b1;
            if (cmd_target == duty) begin
              done <= 1'b1;
            end else begin
              state     <= RAMP;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        RAMP: begin
          // abort takes priority over a coincident boundary step
          if (abort) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (frame_sync) begin
            if (hold_cnt == hold) begin
              hold_cnt <= '0;
              if (last_step) begin
                duty      <= tgt;
                done      <= 1'b1;
                state     <= IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                if (tgt == '0)
                  pwm_enable <= 1'b0;
              end else begin
                duty <= next_duty;
              end
            end else begin
              hold_cnt <= hold_cnt + ONE_H;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: drives commands on the falling edge, checks outputs there too.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_step;
  logic [15:0] cmd_hold;
  logic        abort;
  logic [7:0]  duty;
  logic        pwm_enable;
  logic        frame_sync;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.WIDTH(8), .HOLD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_hold   (cmd_hold),
    .abort      (abort),
    .duty       (duty),
    .pwm_enable (pwm_enable),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one command at the current falling edge; returns one falling edge after the accept edge.
  task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [15:0] h);
    chk("send_ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_step   = s;
    cmd_hold   = h;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Returns at the falling edge just after the next boundary edge.
  task automatic wait_bnd();
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (frame_sync) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk("bnd_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit found;
    rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; cmd_hold = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("init_duty", duty, 0);
    chk("init_ready", cmd_ready, 1);

    // Reset mid-ramp
    send(8'd255, 8'd1, 16'd0);
    repeat (3) wait_bnd();
    chk("pre_rst_duty", duty, 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_duty", duty, 0);
    chk("rst_en", pwm_enable, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (frame_sync) begin
        found = 1'b1;
        break;
      end
    end
    chk("fsync_first", n, 255);

    // Up ramp 0 -> 63 by 16
    send(8'd63, 8'd16, 16'd0);
    chk("up_busy", busy, 1);
    chk("up_ready", cmd_ready, 0);
    chk("up_en", pwm_enable, 1);
    wait_bnd(); chk("up_1", duty, 16); chk("up_1_done", done, 0);
    wait_bnd(); chk("up_2", duty, 32);
    wait_bnd(); chk("up_3", duty, 48); chk("up_3_en", pwm_enable, 1);
    wait_bnd(); chk("up_4", duty, 63); chk("up_4_done", done, 1);
    chk("up_4_ready", cmd_ready, 1);

    // Down to off, accepted in the done cycle
    send(8'd0, 8'd255, 16'd0);
    chk("off_en_held", pwm_enable, 1);
    wait_bnd();
    chk("off_duty", duty, 0);
    chk("off_done", done, 1);
    chk("off_en", pwm_enable, 0);

    // Hold of two extra boundaries
    send(8'd127, 8'd127, 16'd2);
    wait_bnd(); chk("hold_1", duty, 0); chk("hold_1_done", done, 0);
    wait_bnd(); chk("hold_2", duty, 0);
    wait_bnd(); chk("hold_3", duty, 127); chk("hold_3_done", done, 1);

    send(8'd0, 8'd255, 16'd0);
    wait_bnd();
    chk("pre_abort_duty", duty, 0);

    // Busy rejection and abort
    send(8'd255, 8'd1, 16'd0);
    cmd_valid = 1'b1; cmd_target = 8'd5; cmd_step = 8'd5; cmd_hold = '0;
    chk("busy_ready", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_busy", busy, 1);
    repeat (10) wait_bnd();
    chk("ab_duty_pre", duty, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_ready", cmd_ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_en", pwm_enable, 1);
    wait_bnd();
    chk("ab_frozen", duty, 10);

    // Abort on a boundary cycle
    send(8'd255, 8'd1, 16'd0);
    repeat (2) wait_bnd();
    chk("abb_pre", duty, 12);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (frame_sync) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abb_found", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abb_duty", duty, 12);
    chk("abb_done", done, 0);
    chk("abb_ready", cmd_ready, 1);

    // target == duty: immediate done
    send(8'd12, 8'd7, 16'd0);
    chk("eq_done", done, 1);
    chk("eq_duty", duty, 12);
    chk("eq_busy", busy, 0);

    // step 0 acts as 1
    send(8'd0, 8'd255, 16'd0);
    wait_bnd();
    send(8'd3, 8'd0, 16'd0);
    wait_bnd(); chk("s0_1", duty, 1);
    wait_bnd(); chk("s0_2", duty, 2);
    wait_bnd(); chk("s0_3", duty, 3); chk("s0_done", done, 1);

    // No overshoot: 150 -> 200 with step 100
    send(8'd150, 8'd255, 16'd0);
    wait_bnd();
    chk("ov_pre", duty, 150);
    send(8'd200, 8'd100, 16'd0);
    wait_bnd();
    chk("ov_duty", duty, 200);
    chk("ov_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
